toggle_period_meter: RTL and testbench

TOGGLE_PERIOD_METER -- requirements
Module: toggle_period_meter

---
 rtl/toggle_meter_pkg.sv | 15 +
 rtl/sync_edge.sv | 30 +++
 rtl/toggle_period_meter.sv | 110 +++++++++++
 tb/tb_toggle_period_meter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_meter_pkg.sv
// Shared definitions for the toggle period meter: FSM state encoding and
// parameter defaults.
package toggle_meter_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meter_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer per input bit followed by an any-edge detector.
// All history flops reset to zero, so a bit held high through reset reports one edge.
module sync_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] edge_pulse
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            dly   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign edge_pulse = sync2 ^ dly;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures the clk-cycle distance between two consecutive edges of one selected
// toggle input, aborting with a timeout pulse when an edge takes too long.
//
// Handshake: start is a one-cycle request accepted only while busy=0 (state IDLE);
// sel is captured with it. Each accepted start ends with exactly one one-cycle
// pulse, meas_valid (half_period updated) or timeout (half_period unchanged).
module toggle_period_meter
    import toggle_meter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       toggle_in,
    input  logic [1:0]       sel,
    input  logic             start,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] half_period,
    output logic             timeout,
    output meter_state_t     dbg_state
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    meter_state_t     state;
    meter_state_t     state_nxt;
    logic [CNT_W-1:0] counter;
    logic [1:0]       sel_q;
    logic [3:0]       edges;
    logic             sel_edge;
    logic             at_limit;

    sync_edge #(.W(4)) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .din        (toggle_in),
        .edge_pulse (edges)
    );

    assign sel_edge  = edges[sel_q];
    assign at_limit  = (counter == LIMIT);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An edge in the same cycle as the limit wins over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (sel_edge)      state_nxt = ST_MEASURE;
                else if (at_limit) state_nxt = ST_IDLE;
            end
            ST_MEASURE: begin
                if (sel_edge)      state_nxt = ST_DONE;
                else if (at_limit) state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        meas_valid = (state == ST_DONE);
        timeout    = ((state == ST_ARM) || (state == ST_MEASURE)) && at_limit && !sel_edge;
    end

    // Counter saturates at the limit; the FSM leaves before it could wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter     <= '0;
            sel_q       <= '0;
            half_period <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sel_q   <= sel;
                        counter <= '0;
                    end
                end
                ST_ARM: begin
                    if (sel_edge)      counter <= ONE;
                    else if (!at_limit) counter <= counter + ONE;
                end
                ST_MEASURE: begin
                    if (sel_edge)      half_period <= counter;
                    else if (!at_limit) counter <= counter + ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Randomized self-checking bench for toggle_period_meter: the reference model
// finds raw input changes in the recorded stimulus and derives result and timing.
module tb_toggle_period_meter;
  import toggle_meter_pkg::*;

  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   toggle_in = 4'b1000;
  logic [1:0]   sel = 2'd0;
  logic         start = 1'b0;
  logic         busy;
  logic         meas_valid;
  logic [15:0]  half_period;
  logic         timeout;
  meter_state_t dbg_state;

  toggle_period_meter #(.CNT_W(16), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .toggle_in   (toggle_in),
    .sel         (sel),
    .start       (start),
    .busy        (busy),
    .meas_valid  (meas_valid),
    .half_period (half_period),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int          cyc = 0;
  logic [3:0]  eff [0:32767];
  int          mode [4];
  int          per [4];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  int          model_hp = 0;

  // Records the input as the design sees it (zero while reset) and drives the
  // value for the next edge: mode 0 static, 1 periodic, 2 random toggling.
  always @(posedge clk) begin
    cyc = cyc + 1;
    eff[cyc] = reset ? 4'h0 : toggle_in;
    #1;
    for (int b = 0; b < 4; b++) begin
      if (mode[b] == 1 && ((cyc + 1) % per[b]) == 0) toggle_in[b] = ~toggle_in[b];
      if (mode[b] == 2 && $urandom_range(0, 3) == 0) toggle_in[b] = ~toggle_in[b];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: start accepted at edge s. The first raw change c1 >= s-1 arms the
  // measurement if it comes within TO cycles; the result is the gap to the next
  // raw change, if that gap is at most TO. Pulse times follow from the 2-cycle
  // synchronizer plus the edge compare.
  task automatic predict(input int s, input int b, output bit is_to, output int val,
                         output int pcyc);
    int c1 = -1;
    int c2 = -1;
    is_to = 1'b1;
    val = 0;
    for (int c = s - 1; c <= s + TO - 1; c++) begin
      if (eff[c][b] != eff[c-1][b]) begin
        c1 = c;
        break;
      end
    end
    if (c1 < 0) begin
      pcyc = s + TO;
      return;
    end
    for (int c = c1 + 1; c <= c1 + TO; c++) begin
      if (eff[c][b] != eff[c-1][b]) begin
        c2 = c;
        break;
      end
    end
    if (c2 < 0) begin
      pcyc = c1 + 1 + TO;
    end else begin
      is_to = 1'b0;
      val = c2 - c1;
      pcyc = c2 + 2;
    end
  endtask

  // driver: one measurement; rel releases reset together with start, poke
  // issues a second start with sel=3 while busy.
  task automatic run_meas(input int b, input bit rel, input bit poke);
    int   s;
    int   pc;
    int   ev;
    int   epc;
    bit   eto;
    bit   got;
    logic mv_seen;
    logic to_seen;
    int   hp_seen;
    @(posedge clk); #1;
    start = 1'b1;
    sel = b[1:0];
    if (rel) reset = 1'b0;
    s = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    sel = 2'($urandom_range(0, 3));
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1;
      sel = 2'd3;
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    check_eq("busy_after_start", busy, 1);
    got = 1'b0;
    for (int i = 0; i < 3 * TO + 20; i++) begin
      if (meas_valid || timeout) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check_eq("pulse_wait", 0, 1);
      return;
    end
    pc = cyc;
    mv_seen = meas_valid;
    to_seen = timeout;
    hp_seen = int'(half_period);
    predict(s, b, eto, ev, epc);
    check_eq("pulse_kind", int'({mv_seen, to_seen}), eto ? 1 : 2);
    check_eq("pulse_latency", pc - s, epc - s);
    exp_q.push_back(eto ? 16'(model_hp) : 16'(ev));
    if (!eto) model_hp = ev;
    check_eq("half_period", hp_seen, int'(exp_q.pop_front()));
    @(negedge clk);
    check_eq("pulse_width", int'({meas_valid, timeout}), 0);
    check_eq("busy_drop", busy, 0);
  endtask

  task automatic reset_mid_measure();
    int s;
    @(posedge clk); #1;
    start = 1'b1;
    sel = 2'd1;
    s = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < s + 80) @(negedge clk);
    check_eq("busy_before_reset", busy, 1);
    check_eq("state_before_reset", int'(dbg_state), int'(ST_MEASURE));
    #1 reset = 1'b1;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_meas_valid", meas_valid, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_half_period", int'(half_period), 0);
    check_eq("rst_state", int'(dbg_state), int'(ST_IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_no_pulse", int'({meas_valid, timeout, busy}), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_hp = 0;
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      mode[b] = 0;
      per[b] = 1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_meas_valid", meas_valid, 0);
    check_eq("reset_timeout", timeout, 0);
    check_eq("reset_half_period", int'(half_period), 0);
    check_eq("reset_state", int'(dbg_state), int'(ST_IDLE));

    // bit 3 held high through reset: one edge after release, then none
    run_meas(3, 1'b1, 1'b0);

    mode[0] = 1; per[0] = 1;
    run_meas(0, 1'b0, 1'b0);

    mode[2] = 1; per[2] = 4;
    run_meas(2, 1'b0, 1'b0);

    mode[3] = 0;
    run_meas(3, 1'b0, 1'b0);

    mode[1] = 1; per[1] = 100;
    run_meas(1, 1'b0, 1'b0);
    per[1] = 101;
    run_meas(1, 1'b0, 1'b0);

    mode[0] = 1; per[0] = 7;
    mode[3] = 1; per[3] = 2;
    run_meas(0, 1'b0, 1'b1);

    mode[1] = 1; per[1] = 80;
    reset_mid_measure();
    run_meas(1, 1'b0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      for (int b = 0; b < 4; b++) begin
        mode[b] = $urandom_range(0, 2);
        per[b] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 12) : $urandom_range(90, 110);
      end
      run_meas($urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
